// File: rtl/alu_cmd_ctrl.sv
// Byte-serial command front end for an ALU: collects operand/function bytes,
// issues one ALU operation, waits for its result flag and returns two bytes.
module alu_cmd_ctrl #(
  parameter int unsigned TIMEOUT = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  RX_DATA,
  input  logic        RX_VALID,
  output logic [15:0] ALU_A,
  output logic [15:0] ALU_B,
  output logic [3:0]  ALU_FUN,
  output logic        ALU_EN,
  input  logic [15:0] Arith_OUT,
  input  logic [15:0] Logic_OUT,
  input  logic [15:0] SHIFT_OUT,
  input  logic [1:0]  CMP_OUT,
  input  logic        Arith_Flag,
  input  logic        Logic_Flag,
  input  logic        CMP_Flag,
  input  logic        SHIFT_Flag,
  output logic [7:0]  TX_DATA,
  output logic        TX_VALID,
  input  logic        TX_READY,
  output logic        BUSY
);

  localparam int unsigned RW = 16;
  localparam int unsigned CW = 4;
  localparam logic [7:0] CMD_NEW   = 8'hCC;
  localparam logic [7:0] CMD_REUSE = 8'hDD;
  localparam logic [7:0] ERR_BYTE  = 8'hEE;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE, GET_A, GET_B, GET_FUN, ISSUE, WAIT_RES, SEND_LO, SEND_HI, SEND_ERR
  } state_t;

  state_t        state;
  logic [RW-1:0] result;
  logic [CW-1:0] wait_cnt;
  logic          sel_flag;
  logic [RW-1:0] sel_res;

  // Result flag and data chosen by the function group in ALU_FUN[3:2].
  always_comb begin
    sel_flag = 1'b0;
    sel_res  = '0;
    case (ALU_FUN[3:2])
      2'b00: begin sel_flag = Arith_Flag; sel_res = Arith_OUT; end
      2'b01: begin sel_flag = Logic_Flag; sel_res = Logic_OUT; end
      2'b10: begin sel_flag = CMP_Flag;   sel_res = {14'h0000, CMP_OUT}; end
      default: begin sel_flag = SHIFT_Flag; sel_res = SHIFT_OUT; end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      ALU_A    <= '0;
      ALU_B    <= '0;
      ALU_FUN  <= '0;
      ALU_EN   <= 1'b0;
      result   <= '0;
      wait_cnt <= '0;
      TX_DATA  <= '0;
      TX_VALID <= 1'b0;
      BUSY     <= 1'b0;
    end else begin
      ALU_EN <= 1'b0;
      case (state)
        IDLE: begin
          if (RX_VALID && RX_DATA == CMD_NEW) begin
            state <= GET_A;
            BUSY  <= 1'b1;
          end else if (RX_VALID && RX_DATA == CMD_REUSE) begin
            state <= GET_FUN;
            BUSY  <= 1'b1;
          end
        end
        GET_A: begin
          if (RX_VALID) begin
            ALU_A <= {8'h00, RX_DATA};
            state <= GET_B;
          end
        end
        GET_B: begin
          if (RX_VALID) begin
            ALU_B <= {8'h00, RX_DATA};
            state <= GET_FUN;
          end
        end
        GET_FUN: begin
          if (RX_VALID) begin
            ALU_FUN <= RX_DATA[3:0];
            ALU_EN  <= 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          wait_cnt <= '0;
          state    <= WAIT_RES;
        end
        // Only flags seen here count; the ISSUE cycle is deliberately skipped.
        WAIT_RES: begin
          if (sel_flag) begin
            result   <= sel_res;
            TX_DATA  <= sel_res[7:0];
            TX_VALID <= 1'b1;
            state    <= SEND_LO;
          end else if (wait_cnt == CNT_LAST) begin
            TX_DATA  <= ERR_BYTE;
            TX_VALID <= 1'b1;
            state    <= SEND_ERR;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        SEND_LO: begin
          if (TX_READY) begin
            TX_DATA <= result[15:8];
            state   <= SEND_HI;
          end else begin
            TX_DATA <= result[7:0];
          end
        end
        SEND_HI, SEND_ERR: begin
          if (TX_READY) begin
            TX_VALID <= 1'b0;
            TX_DATA  <= '0;
            BUSY     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          TX_VALID <= 1'b0;
          BUSY     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Directed bench for alu_cmd_ctrl: command framing, result return, timeout,
// back-pressure and reset abort, with hand-computed expected bytes.
module tb_alu_cmd_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  RX_DATA;
  logic        RX_VALID;
  logic [15:0] ALU_A, ALU_B;
  logic [3:0]  ALU_FUN;
  logic        ALU_EN;
  logic [15:0] Arith_OUT, Logic_OUT, SHIFT_OUT;
  logic [1:0]  CMP_OUT;
  logic        Arith_Flag, Logic_Flag, CMP_Flag, SHIFT_Flag;
  logic [7:0]  TX_DATA;
  logic        TX_VALID;
  logic        TX_READY;
  logic        BUSY;

  int errors = 0;
  int checks = 0;

  alu_cmd_ctrl #(.TIMEOUT(4)) dut (
    .CLK(CLK), .RST(RST), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN),
    .Arith_OUT(Arith_OUT), .Logic_OUT(Logic_OUT), .SHIFT_OUT(SHIFT_OUT),
    .CMP_OUT(CMP_OUT), .Arith_Flag(Arith_Flag), .Logic_Flag(Logic_Flag),
    .CMP_Flag(CMP_Flag), .SHIFT_Flag(SHIFT_Flag), .TX_DATA(TX_DATA),
    .TX_VALID(TX_VALID), .TX_READY(TX_READY), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic send_byte(input logic [7:0] b);
    RX_DATA  = b;
    RX_VALID = 1'b1;
    @(posedge CLK); #1;
    RX_VALID = 1'b0;
  endtask

  // Called right after the function byte: one cycle later raise one flag for one cycle.
  task automatic alu_respond(input logic [1:0] kind, input logic [15:0] val);
    @(posedge CLK); #1;
    case (kind)
      2'd0: begin Arith_OUT = val; Arith_Flag = 1'b1; end
      2'd1: begin Logic_OUT = val; Logic_Flag = 1'b1; end
      2'd2: begin CMP_OUT = val[1:0]; CMP_Flag = 1'b1; end
      default: begin SHIFT_OUT = val; SHIFT_Flag = 1'b1; end
    endcase
    @(posedge CLK); #1;
    Arith_Flag = 1'b0; Logic_Flag = 1'b0; CMP_Flag = 1'b0; SHIFT_Flag = 1'b0;
  endtask

  // Waits (bounded) for a TX byte, captures it and completes the handshake.
  task automatic tx_accept(output logic [7:0] data, output logic ok);
    int n;
    n = 0;
    while (TX_VALID !== 1'b1 && n < 40) begin
      @(posedge CLK); #1;
      n++;
    end
    ok   = (TX_VALID === 1'b1);
    data = TX_DATA;
    if (ok) begin
      TX_READY = 1'b1;
      @(posedge CLK); #1;
      TX_READY = 1'b0;
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    checks++; if (ALU_A !== 16'h0000) begin errors++; $display("FAIL reset_alu_a: got %h want 0000", ALU_A); end
    checks++; if (ALU_B !== 16'h0000) begin errors++; $display("FAIL reset_alu_b: got %h want 0000", ALU_B); end
    checks++; if (ALU_FUN !== 4'h0) begin errors++; $display("FAIL reset_alu_fun: got %h want 0", ALU_FUN); end
    checks++; if (ALU_EN !== 1'b0) begin errors++; $display("FAIL reset_alu_en: got %b want 0", ALU_EN); end
    checks++; if (TX_DATA !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h want 00", TX_DATA); end
    checks++; if (TX_VALID !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b want 0", TX_VALID); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", BUSY); end
    RST = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic test_arith();
    send_byte(8'hCC);
    checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL arith_busy: got %b want 1", BUSY); end
    send_byte(8'h03);
    send_byte(8'h01);
    send_byte(8'h00);
    checks++; if (ALU_EN !== 1'b1) begin errors++; $display("FAIL arith_en_latency: got %b want 1", ALU_EN); end
    checks++; if (ALU_A !== 16'h0003 || ALU_B !== 16'h0001 || ALU_FUN !== 4'h0) begin
      errors++; $display("FAIL arith_operands: got A=%h B=%h F=%h want 0003 0001 0", ALU_A, ALU_B, ALU_FUN);
    end
    @(posedge CLK); #1;
    checks++; if (ALU_EN !== 1'b0) begin errors++; $display("FAIL arith_en_pulse: got %b want 0", ALU_EN); end
    Arith_OUT = 16'h0004; Arith_Flag = 1'b1;
    @(posedge CLK); #1;
    Arith_Flag = 1'b0;
    checks++; if (TX_VALID !== 1'b1 || TX_DATA !== 8'h04) begin
      errors++; $display("FAIL arith_lo: got valid=%b data=%h want 1 04", TX_VALID, TX_DATA);
    end
    TX_READY = 1'b1; @(posedge CLK); #1; TX_READY = 1'b0;
    checks++; if (TX_VALID !== 1'b1 || TX_DATA !== 8'h00) begin
      errors++; $display("FAIL arith_hi: got valid=%b data=%h want 1 00", TX_VALID, TX_DATA);
    end
    TX_READY = 1'b1; @(posedge CLK); #1; TX_READY = 1'b0;
    checks++; if (TX_VALID !== 1'b0 || BUSY !== 1'b0) begin
      errors++; $display("FAIL arith_done: got valid=%b busy=%b want 0 0", TX_VALID, BUSY);
    end
  endtask

  task automatic test_reuse();
    logic [7:0] d;
    logic ok;
    send_byte(8'hCC); send_byte(8'h03); send_byte(8'h07); send_byte(8'h00);
    alu_respond(2'd0, 16'h000A);
    tx_accept(d, ok);
    checks++; if (!ok || d !== 8'h0A) begin errors++; $display("FAIL setup_lo: got %h valid=%b want 0a", d, ok); end
    tx_accept(d, ok);
    send_byte(8'hDD);
    send_byte(8'h0B);
    checks++; if (ALU_EN !== 1'b1 || ALU_FUN !== 4'hB || ALU_A !== 16'h0003 || ALU_B !== 16'h0007) begin
      errors++; $display("FAIL reuse_issue: got en=%b F=%h A=%h B=%h want 1 b 0003 0007", ALU_EN, ALU_FUN, ALU_A, ALU_B);
    end
    // A stray arith flag first must be ignored; the CMP flag follows.
    @(posedge CLK); #1;
    Arith_OUT = 16'h1234; Arith_Flag = 1'b1;
    @(posedge CLK); #1;
    Arith_Flag = 1'b0; CMP_OUT = 2'b11; CMP_Flag = 1'b1;
    @(posedge CLK); #1;
    CMP_Flag = 1'b0;
    tx_accept(d, ok);
    checks++; if (!ok || d !== 8'h03) begin errors++; $display("FAIL reuse_lo: got %h valid=%b want 03", d, ok); end
    tx_accept(d, ok);
    checks++; if (!ok || d !== 8'h00) begin errors++; $display("FAIL reuse_hi: got %h valid=%b want 00", d, ok); end
  endtask

  task automatic test_backpressure();
    logic [7:0] d;
    logic ok;
    logic [7:0] junk [5];
    junk[0] = 8'hCC; junk[1] = 8'hDD; junk[2] = 8'h01; junk[3] = 8'hCC; junk[4] = 8'h0F;
    send_byte(8'hCC); send_byte(8'h10); send_byte(8'h20); send_byte(8'h04);
    alu_respond(2'd1, 16'h1234);
    for (int i = 0; i < 5; i++) begin
      RX_DATA = junk[i]; RX_VALID = 1'b1;
      checks++; if (TX_VALID !== 1'b1 || TX_DATA !== 8'h34) begin
        errors++; $display("FAIL hold_%0d: got valid=%b data=%h want 1 34", i, TX_VALID, TX_DATA);
      end
      @(posedge CLK); #1;
    end
    RX_VALID = 1'b0;
    tx_accept(d, ok);
    checks++; if (!ok || d !== 8'h34) begin errors++; $display("FAIL bp_lo: got %h valid=%b want 34", d, ok); end
    tx_accept(d, ok);
    checks++; if (!ok || d !== 8'h12) begin errors++; $display("FAIL bp_hi: got %h valid=%b want 12", d, ok); end
    checks++; if (BUSY !== 1'b0 || ALU_A !== 16'h0010 || ALU_FUN !== 4'h4) begin
      errors++; $display("FAIL bp_rx_dropped: got busy=%b A=%h F=%h want 0 0010 4", BUSY, ALU_A, ALU_FUN);
    end
  endtask

  task automatic test_timeout();
    int n;
    send_byte(8'hCC); send_byte(8'h07); send_byte(8'h0D); send_byte(8'h04);
    Arith_OUT = 16'h5555; Arith_Flag = 1'b1;
    n = 0;
    while (TX_VALID !== 1'b1 && n < 20) begin @(posedge CLK); #1; n++; end
    Arith_Flag = 1'b0;
    checks++; if (n != 5 || TX_DATA !== 8'hEE) begin
      errors++; $display("FAIL timeout_err: got cycles=%0d data=%h want 5 ee", n, TX_DATA);
    end
    TX_READY = 1'b1; @(posedge CLK); #1; TX_READY = 1'b0;
    checks++; if (TX_VALID !== 1'b0 || BUSY !== 1'b0) begin
      errors++; $display("FAIL timeout_single: got valid=%b busy=%b want 0 0", TX_VALID, BUSY);
    end
  endtask

  task automatic test_issue_flag();
    int n;
    send_byte(8'hCC); send_byte(8'h01); send_byte(8'h02); send_byte(8'h00);
    Arith_OUT = 16'h0003; Arith_Flag = 1'b1;
    @(posedge CLK); #1;
    Arith_Flag = 1'b0;
    n = 1;
    while (TX_VALID !== 1'b1 && n < 20) begin @(posedge CLK); #1; n++; end
    checks++; if (n != 5 || TX_DATA !== 8'hEE) begin
      errors++; $display("FAIL issue_flag_ignored: got cycles=%0d data=%h want 5 ee", n, TX_DATA);
    end
    TX_READY = 1'b1; @(posedge CLK); #1; TX_READY = 1'b0;
  endtask

  task automatic test_abort();
    logic [7:0] d;
    logic ok;
    send_byte(8'h55);
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL junk_ignored: got busy=%b want 0", BUSY); end
    send_byte(8'hCC); send_byte(8'h05);
    RST = 1'b1;
    #2;
    checks++; if (BUSY !== 1'b0 || ALU_A !== 16'h0000) begin
      errors++; $display("FAIL abort_async: got busy=%b A=%h want 0 0000", BUSY, ALU_A);
    end
    @(posedge CLK); #1;
    RST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      checks++; if (TX_VALID !== 1'b0 || BUSY !== 1'b0) begin
        errors++; $display("FAIL abort_quiet_%0d: got valid=%b busy=%b want 0 0", i, TX_VALID, BUSY);
      end
    end
    send_byte(8'hCC); send_byte(8'h06); send_byte(8'h02); send_byte(8'h03);
    checks++; if (ALU_A !== 16'h0006 || ALU_B !== 16'h0002 || ALU_FUN !== 4'h3) begin
      errors++; $display("FAIL abort_new_cmd: got A=%h B=%h F=%h want 0006 0002 3", ALU_A, ALU_B, ALU_FUN);
    end
    alu_respond(2'd0, 16'h0003);
    tx_accept(d, ok);
    checks++; if (!ok || d !== 8'h03) begin errors++; $display("FAIL abort_lo: got %h valid=%b want 03", d, ok); end
    tx_accept(d, ok);
    checks++; if (!ok || d !== 8'h00) begin errors++; $display("FAIL abort_hi: got %h valid=%b want 00", d, ok); end
  endtask

  task automatic test_shift();
    logic [7:0] d;
    logic ok;
    send_byte(8'hCC); send_byte(8'h81); send_byte(8'h02); send_byte(8'hFD);
    checks++; if (ALU_FUN !== 4'hD) begin errors++; $display("FAIL shift_fun: got %h want d", ALU_FUN); end
    alu_respond(2'd3, 16'hABCD);
    tx_accept(d, ok);
    checks++; if (!ok || d !== 8'hCD) begin errors++; $display("FAIL shift_lo: got %h valid=%b want cd", d, ok); end
    tx_accept(d, ok);
    checks++; if (!ok || d !== 8'hAB) begin errors++; $display("FAIL shift_hi: got %h valid=%b want ab", d, ok); end
    checks++; if (BUSY !== 1'b0 || TX_VALID !== 1'b0) begin
      errors++; $display("FAIL shift_idle: got busy=%b valid=%b want 0 0", BUSY, TX_VALID);
    end
  endtask

  initial begin
    RST = 1'b1; RX_DATA = '0; RX_VALID = 1'b0; TX_READY = 1'b0;
    Arith_OUT = '0; Logic_OUT = '0; SHIFT_OUT = '0; CMP_OUT = '0;
    Arith_Flag = 1'b0; Logic_Flag = 1'b0; CMP_Flag = 1'b0; SHIFT_Flag = 1'b0;
    test_reset();
    test_arith();
    test_reuse();
    test_backpressure();
    test_timeout();
    test_issue_flag();
    test_abort();
    test_shift();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
